// File: rtl/protected_read_output_controller.sv
// Sequencing FSM for the protected-read output buffer: takes one result from the
// lookup engine, serves it to a consumer, and drops it if the consumer never asks.
module protected_read_output_controller #(
  parameter int timeout_cycles = 256,
  parameter int timer_width    = 9,
  parameter int count_width    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   result_valid,
  output logic                   result_ready,
  input  logic                   consumer_req,
  output logic                   consumer_valid,
  input  logic                   consumer_ack,
  output logic                   buf_write_enable,
  output logic                   buf_read_enable,
  output logic                   buf_status_set,
  output logic                   buf_status_reset,
  output logic                   busy,
  output logic                   timeout_event,
  output logic [count_width-1:0] served_count,
  output logic [count_width-1:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FULL = 2'd1,
    READ = 2'd2
  } state_t;

  localparam logic [timer_width-1:0] TIMER_LAST = timer_width'(timeout_cycles - 1);

  state_t                 state;
  state_t                 state_next;
  logic [timer_width-1:0] timer;
  logic [timer_width-1:0] timer_next;
  logic [count_width-1:0] served_next;
  logic [count_width-1:0] drop_next;
  logic                   timeout_next;

  function automatic logic [count_width-1:0] sat_inc(input logic [count_width-1:0] value);
    if (&value) begin
      return value;
    end
    return value + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      timer         <= '0;
      served_count  <= '0;
      drop_count    <= '0;
      timeout_event <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      served_count  <= served_next;
      drop_count    <= drop_next;
      timeout_event <= timeout_next;
    end
  end

  // Priority: flush, then consumer handshake, then timeout, then producer.
  always_comb begin
    state_next       = state;
    timer_next       = timer;
    served_next      = served_count;
    drop_next        = drop_count;
    timeout_next     = 1'b0;
    result_ready     = 1'b0;
    consumer_valid   = 1'b0;
    buf_write_enable = 1'b0;
    buf_read_enable  = 1'b0;
    buf_status_set   = 1'b0;
    buf_status_reset = 1'b0;
    busy             = (state != IDLE);

    if (flush) begin
      buf_status_reset = 1'b1;
      state_next       = IDLE;
      timer_next       = '0;
    end else begin
      case (state)
        IDLE: begin
          result_ready = 1'b1;
          timer_next   = '0;
          if (result_valid) begin
            buf_write_enable = 1'b1;
            buf_status_set   = 1'b1;
            state_next       = FULL;
          end
        end
        FULL: begin
          timer_next = timer + 1'b1;
          if (consumer_req) begin
            buf_read_enable = 1'b1;
            state_next      = READ;
          end else if (timer == TIMER_LAST) begin
            buf_status_reset = 1'b1;
            timeout_next     = 1'b1;
            drop_next        = sat_inc(drop_count);
            state_next       = IDLE;
            timer_next       = '0;
          end
        end
        READ: begin
          buf_read_enable = 1'b1;
          consumer_valid  = 1'b1;
          if (consumer_ack) begin
            buf_status_reset = 1'b1;
            served_next      = sat_inc(served_count);
            state_next       = IDLE;
            timer_next       = '0;
          end
        end
        default: begin
          state_next = IDLE;
          timer_next = '0;
        end
      endcase
    end

    // Buffer strobes must stay quiet while reset is held, whatever the inputs do.
    if (!reset_n) begin
      result_ready     = 1'b0;
      consumer_valid   = 1'b0;
      buf_write_enable = 1'b0;
      buf_read_enable  = 1'b0;
      buf_status_set   = 1'b0;
      buf_status_reset = 1'b0;
      busy             = 1'b0;
    end
  end

endmodule

// File: tb/tb_protected_read_output_controller.sv
// Bench for protected_read_output_controller: directed scenarios with literal
// expectations, then random traffic checked every cycle against a behavioural model.
module tb_protected_read_output_controller;

  localparam int T    = 4;
  localparam int CW   = 2;
  localparam int TW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  localparam int EMPTY   = 0;
  localparam int WAITING = 1;
  localparam int READING = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          result_valid;
  logic          result_ready;
  logic          consumer_req;
  logic          consumer_valid;
  logic          consumer_ack;
  logic          buf_write_enable;
  logic          buf_read_enable;
  logic          buf_status_set;
  logic          buf_status_reset;
  logic          busy;
  logic          timeout_event;
  logic [CW-1:0] served_count;
  logic [CW-1:0] drop_count;

  int vectors = 0;
  int errors  = 0;

  protected_read_output_controller #(
    .timeout_cycles(T),
    .timer_width   (TW),
    .count_width   (CW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush           (flush),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .consumer_req    (consumer_req),
    .consumer_valid  (consumer_valid),
    .consumer_ack    (consumer_ack),
    .buf_write_enable(buf_write_enable),
    .buf_read_enable (buf_read_enable),
    .buf_status_set  (buf_status_set),
    .buf_status_reset(buf_status_reset),
    .busy            (busy),
    .timeout_event   (timeout_event),
    .served_count    (served_count),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: is a result held, how long has it waited, is it being read.
  int m_phase;
  int m_wait;
  int m_served;
  int m_drop;
  bit m_tev;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase  <= EMPTY;
      m_wait   <= 0;
      m_served <= 0;
      m_drop   <= 0;
      m_tev    <= 1'b0;
    end else begin
      m_tev <= 1'b0;
      if (flush) begin
        m_phase <= EMPTY;
      end else if (m_phase == EMPTY) begin
        if (result_valid) begin
          m_phase <= WAITING;
          m_wait  <= 1;
        end
      end else if (m_phase == WAITING) begin
        if (consumer_req) begin
          m_phase <= READING;
        end else if (m_wait == T) begin
          m_phase <= EMPTY;
          m_tev   <= 1'b1;
          m_drop  <= (m_drop < CMAX) ? m_drop + 1 : CMAX;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (consumer_ack) begin
        m_phase  <= EMPTY;
        m_served <= (m_served < CMAX) ? m_served + 1 : CMAX;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  bit e_ready, e_we, e_re, e_cv, e_rst, e_busy;

  always @(negedge clk) begin
    e_ready = reset_n && !flush && m_phase == EMPTY;
    e_we    = e_ready && result_valid;
    e_re    = reset_n && !flush &&
              ((m_phase == WAITING && consumer_req) || m_phase == READING);
    e_cv    = reset_n && !flush && m_phase == READING;
    e_rst   = reset_n && (flush || (m_phase == READING && consumer_ack) ||
              (m_phase == WAITING && !consumer_req && m_wait == T));
    e_busy  = reset_n && m_phase != EMPTY;
    vectors++;
    chk("result_ready", result_ready, e_ready);
    chk("buf_write_enable", buf_write_enable, e_we);
    chk("buf_status_set", buf_status_set, e_we);
    chk("buf_read_enable", buf_read_enable, e_re);
    chk("consumer_valid", consumer_valid, e_cv);
    chk("buf_status_reset", buf_status_reset, e_rst);
    chk("busy", busy, e_busy);
    chk("timeout_event", timeout_event, m_tev);
    chk("served_count", served_count, m_served);
    chk("drop_count", drop_count, m_drop);
    chk("we_re_exclusive", buf_write_enable & buf_read_enable, 0);
    chk("set_reset_exclusive", buf_status_set & buf_status_reset, 0);
    chk("valid_only_in_read", consumer_valid & (m_phase != READING), 0);
  end

  task automatic drive(input bit v, input bit r, input bit a, input bit f);
    @(posedge clk);
    #1;
    result_valid = v;
    consumer_req = r;
    consumer_ack = a;
    flush        = f;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; result_valid = 1'b0;
    consumer_req = 1'b0; consumer_ack = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_ready", result_ready, 0);
    chk("reset_served", served_count, 0);
    #1 reset_n = 1'b1;

    // Load, wait, request in the last FULL cycle (request beats timeout), serve.
    drive(1, 0, 0, 0); #5;
    chk("load_ready", result_ready, 1);
    chk("load_we", buf_write_enable, 1);
    chk("load_set", buf_status_set, 1);
    drive(0, 0, 0, 0); #5;
    chk("full_busy", busy, 1);
    chk("full_ready", result_ready, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0); #5;
    chk("req_re", buf_read_enable, 1);
    chk("req_beats_timeout", buf_status_reset, 0);
    drive(0, 0, 0, 0); #5;
    chk("read_cv", consumer_valid, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0); #5;
    chk("ack_status_reset", buf_status_reset, 1);
    drive(0, 0, 0, 0); #5;
    chk("served_one", served_count, 1);
    chk("ready_after_ack", result_ready, 1);
    chk("no_drop_yet", drop_count, 0);

    // Timeout: no request for T FULL cycles.
    drive(1, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0);
    drive(0, 0, 0, 0); #5;
    chk("timeout_status_reset", buf_status_reset, 1);
    drive(0, 0, 0, 0); #5;
    chk("timeout_event", timeout_event, 1);
    chk("drop_one", drop_count, 1);
    chk("timeout_idle", busy, 0);

    // Flush in READ together with ack; flush in IDLE together with valid.
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 1); #5;
    chk("flush_status_reset", buf_status_reset, 1);
    chk("flush_cv", consumer_valid, 0);
    chk("flush_re", buf_read_enable, 0);
    drive(0, 0, 0, 0); #5;
    chk("flush_served_kept", served_count, 1);
    chk("flush_idle", busy, 0);
    drive(1, 0, 0, 1); #5;
    chk("flush_idle_we", buf_write_enable, 0);
    drive(0, 0, 0, 0); #5;
    chk("flush_idle_stays", busy, 0);

    // Four more served results saturate the 2-bit counter at 3.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      drive(0, 1, 0, 0);
      drive(0, 0, 1, 0);
    end
    drive(0, 0, 0, 0); #5;
    chk("served_saturated", served_count, 3);

    // Reset pulsed in the middle of FULL.
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    #5 reset_n = 1'b0;
    #1;
    chk("midreset_ready", result_ready, 0);
    chk("midreset_served", served_count, 0);
    chk("midreset_drop", drop_count, 0);
    chk("midreset_busy", busy, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("release_ready", result_ready, 1);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      reset_n      = ($urandom_range(0, 299) != 0);
      result_valid = $urandom_range(0, 1);
      consumer_req = ($urandom_range(0, 5) == 0);
      consumer_ack = ($urandom_range(0, 2) == 0);
      flush        = ($urandom_range(0, 24) == 0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1; flush = 1'b0; result_valid = 1'b0;
    consumer_req = 1'b0; consumer_ack = 1'b0;
    repeat (2) @(posedge clk);
    #6;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
